// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encodings and default bus widths.
// Commands are {CS_N, RAS_N, CAS_N, WE_N}.
package sdram_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int BA_W_DEF   = 2;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

endpackage

// File: rtl/sdram_req_latch.sv
// Pending-request latch: a one-cycle trigger sets the bit, the grant clears it.
// Latency: pend is visible the cycle after trig; a trig in the clearing cycle wins.
// No backpressure: repeated triggers while pending merge into one request.
module sdram_req_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    input  logic clr,
    output logic pend
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            pend <= trig | (pend & ~clr);
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init hold-off, then refresh > write > read grants.
// Latency: grant pulse and bus handover one cycle after the winning request is sampled.
// Backpressure: requests stay pending until granted; a watchdog reclaims stuck grants.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BA_W    = BA_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              wr_trig,
    input  logic              rd_trig,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic              wr_dq_oe,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic              sdram_cke,
    output logic              dq_oe,
    output logic              grant_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            wr_pend;
    logic            rd_pend;
    logic            grant_aref;
    logic            grant_wr;
    logic            grant_rd;
    logic            end_hit;
    logic            wd_expired;

    sdram_req_latch u_wr_latch (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .trig  (wr_trig),
        .clr   (grant_wr),
        .pend  (wr_pend)
    );

    sdram_req_latch u_rd_latch (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .trig  (rd_trig),
        .clr   (grant_rd),
        .pend  (rd_pend)
    );

    // Arbitration decision, taken only while idle in S_ARBIT.
    always_comb begin
        grant_aref = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        if (state == S_ARBIT) begin
            if (aref_req)     grant_aref = 1'b1;
            else if (wr_pend) grant_wr   = 1'b1;
            else if (rd_pend) grant_rd   = 1'b1;
        end
    end

    // End strobes only count in their own grant state.
    assign end_hit = ((state == S_AREF)  && aref_end) ||
                     ((state == S_WRITE) && wr_end)   ||
                     ((state == S_READ)  && rd_end);

    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            grant_err <= 1'b0;
            sdram_cke <= 1'b0;
            wd        <= '0;
        end else begin
            sdram_cke <= 1'b1;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            grant_err <= 1'b0;
            case (state)
                S_INIT: begin
                    if (init_end) state <= S_ARBIT;
                end
                S_ARBIT: begin
                    wd <= '0;
                    if (grant_aref) begin
                        state   <= S_AREF;
                        aref_en <= 1'b1;
                    end else if (grant_wr) begin
                        state <= S_WRITE;
                        wr_en <= 1'b1;
                    end else if (grant_rd) begin
                        state <= S_READ;
                        rd_en <= 1'b1;
                    end
                end
                S_AREF, S_WRITE, S_READ: begin
                    if (end_hit) begin
                        state <= S_ARBIT;
                    end else if (wd_expired) begin
                        state     <= S_ARBIT;
                        grant_err <= 1'b1;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Pin mux; until CKE is up (i.e. in or just out of reset) the pins idle at NOP.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
        dq_oe      = 1'b0;
        case (state)
            S_INIT: begin
                if (sdram_cke) begin
                    sdram_cmd  = init_cmd;
                    sdram_addr = init_addr;
                end
            end
            S_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
                dq_oe      = wr_dq_oe;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit with a short watchdog (TIMEOUT=16).
module tb_sdram_arbit;

    localparam logic [3:0]  NOP     = 4'b0111;
    localparam logic [3:0]  I_CMD   = 4'b0010;
    localparam logic [12:0] I_ADDR  = 13'h0400;
    localparam logic [3:0]  A_CMD   = 4'b0001;
    localparam logic [12:0] A_ADDR  = 13'h00AA;
    localparam logic [3:0]  W_CMD   = 4'b0100;
    localparam logic [12:0] W_ADDR  = 13'h0123;
    localparam logic [1:0]  W_BA    = 2'd2;
    localparam logic [3:0]  R_CMD   = 4'b0101;
    localparam logic [12:0] R_ADDR  = 13'h0456;
    localparam logic [1:0]  R_BA    = 2'd1;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_trig = 1'b0, rd_trig = 1'b0, init_end = 1'b0;
    logic        aref_req = 1'b0, aref_end = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
    logic        wr_dq_oe = 1'b0;
    logic        aref_en, wr_en, rd_en, sdram_cke, dq_oe, grant_err;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;

    int n_cmp = 0;
    int n_err = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    sdram_arbit #(.TIMEOUT(16), .ADDR_W(13), .BA_W(2)) dut (
        .CLOCK_50 (CLOCK_50), .rst_n (rst_n),
        .wr_trig (wr_trig), .rd_trig (rd_trig),
        .init_end (init_end), .init_cmd (I_CMD), .init_addr (I_ADDR),
        .aref_req (aref_req), .aref_end (aref_end), .aref_cmd (A_CMD), .aref_addr (A_ADDR),
        .wr_end (wr_end), .wr_cmd (W_CMD), .wr_addr (W_ADDR), .wr_ba (W_BA), .wr_dq_oe (wr_dq_oe),
        .rd_end (rd_end), .rd_cmd (R_CMD), .rd_addr (R_ADDR), .rd_ba (R_BA),
        .aref_en (aref_en), .wr_en (wr_en), .rd_en (rd_en),
        .sdram_cmd (sdram_cmd), .sdram_addr (sdram_addr), .sdram_ba (sdram_ba),
        .sdram_cke (sdram_cke), .dq_oe (dq_oe), .grant_err (grant_err)
    );

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        #5;
        n_cmp++; if ({sdram_cke, dq_oe, aref_en, wr_en, rd_en, grant_err} !== 6'b0) begin
            n_err++; $display("FAIL rst_ctrl: got %b want 000000", {sdram_cke, dq_oe, aref_en, wr_en, rd_en, grant_err}); end
        n_cmp++; if ({sdram_cmd, sdram_addr, sdram_ba} !== {NOP, 13'h0, 2'h0}) begin
            n_err++; $display("FAIL rst_bus: got cmd %b addr %h ba %h want 0111/0/0", sdram_cmd, sdram_addr, sdram_ba); end
        #95 rst_n = 1'b1;
        step();
        n_cmp++; if (sdram_cke !== 1'b1) begin
            n_err++; $display("FAIL cke_rise: got %b want 1", sdram_cke); end
        n_cmp++; if ({sdram_cmd, sdram_addr} !== {I_CMD, I_ADDR}) begin
            n_err++; $display("FAIL init_mux: got %b/%h want %b/%h", sdram_cmd, sdram_addr, I_CMD, I_ADDR); end
        repeat (9990) step();
        n_cmp++; if (sdram_cmd !== I_CMD) begin
            n_err++; $display("FAIL init_hold: got %b want %b", sdram_cmd, I_CMD); end
        init_end = 1'b1;
        step();
        n_cmp++; if ({sdram_cmd, sdram_addr, dq_oe} !== {NOP, 13'h0, 1'b0}) begin
            n_err++; $display("FAIL arbit_entry: got %b/%h/%b want 0111/0/0", sdram_cmd, sdram_addr, dq_oe); end
    endtask

    task automatic test_aref_priority();
        aref_req = 1'b1; wr_trig = 1'b1;
        step();
        aref_req = 1'b0; wr_trig = 1'b0;
        n_cmp++; if ({aref_en, wr_en, sdram_cmd, sdram_addr} !== {2'b10, A_CMD, A_ADDR}) begin
            n_err++; $display("FAIL aref_first: got en %b%b cmd %b addr %h", aref_en, wr_en, sdram_cmd, sdram_addr); end
        step();
        n_cmp++; if ({aref_en, dut.wr_pend} !== 2'b01) begin
            n_err++; $display("FAIL aref_hold: got aref_en %b wr_pend %b want 0 1", aref_en, dut.wr_pend); end
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        n_cmp++; if ({wr_en, sdram_cmd} !== {1'b0, NOP}) begin
            n_err++; $display("FAIL aref_gap: got wr_en %b cmd %b want 0 0111", wr_en, sdram_cmd); end
        step();
        n_cmp++; if ({wr_en, sdram_cmd, sdram_addr, sdram_ba} !== {1'b1, W_CMD, W_ADDR, W_BA}) begin
            n_err++; $display("FAIL wr_after_aref: got en %b cmd %b addr %h ba %h", wr_en, sdram_cmd, sdram_addr, sdram_ba); end
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
    endtask

    task automatic test_wr_over_rd();
        wr_trig = 1'b1; rd_trig = 1'b1;
        step();
        wr_trig = 1'b0; rd_trig = 1'b0;
        step();
        n_cmp++; if ({wr_en, rd_en} !== 2'b10) begin
            n_err++; $display("FAIL wr_first: got wr_en %b rd_en %b want 1 0", wr_en, rd_en); end
        wr_dq_oe = 1'b1;
        #1;
        n_cmp++; if (dq_oe !== 1'b1) begin
            n_err++; $display("FAIL dq_oe_write: got %b want 1", dq_oe); end
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        n_cmp++; if ({rd_en, dq_oe, sdram_cmd} !== {2'b00, NOP}) begin
            n_err++; $display("FAIL rd_gap: got rd_en %b dq_oe %b cmd %b", rd_en, dq_oe, sdram_cmd); end
        step();
        n_cmp++; if ({rd_en, dq_oe, sdram_cmd, sdram_addr, sdram_ba} !== {2'b10, R_CMD, R_ADDR, R_BA}) begin
            n_err++; $display("FAIL rd_grant: got en %b oe %b cmd %b addr %h ba %h", rd_en, dq_oe, sdram_cmd, sdram_addr, sdram_ba); end
        rd_end = 1'b1; wr_dq_oe = 1'b0;
        step();
        rd_end = 1'b0;
    endtask

    task automatic test_merge();
        int wr_seen;
        rd_trig = 1'b1;
        step();
        rd_trig = 1'b0;
        step();
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            wr_trig = 1'b1;
            step();
            wr_trig = 1'b0;
            if (wr_en) wr_seen++;
            step();
            if (wr_en) wr_seen++;
        end
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        if (wr_en) wr_seen++;
        n_cmp++; if (wr_seen !== 0) begin
            n_err++; $display("FAIL merge_during_read: got %0d wr_en want 0", wr_seen); end
        step();
        n_cmp++; if (wr_en !== 1'b1) begin
            n_err++; $display("FAIL merge_grant: got wr_en %b want 1", wr_en); end
        wr_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        step();
        n_cmp++; if (wr_en !== 1'b1) begin
            n_err++; $display("FAIL retrig_grant: got wr_en %b want 1", wr_en); end
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        wr_seen = 0;
        repeat (5) begin
            step();
            if (wr_en) wr_seen++;
        end
        n_cmp++; if (wr_seen !== 0) begin
            n_err++; $display("FAIL merge_extra: got %0d extra wr_en want 0", wr_seen); end
    endtask

    task automatic test_timeout();
        int early;
        wr_trig = 1'b1;
        step();
        wr_trig = 1'b0;
        step();
        n_cmp++; if (wr_en !== 1'b1) begin
            n_err++; $display("FAIL to_grant: got wr_en %b want 1", wr_en); end
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (grant_err) early++;
        end
        n_cmp++; if ({early, sdram_cmd} !== {32'd0, W_CMD}) begin
            n_err++; $display("FAIL to_early: got %0d early pulses cmd %b want 0 %b", early, sdram_cmd, W_CMD); end
        step();
        n_cmp++; if ({grant_err, sdram_cmd, sdram_addr} !== {1'b1, NOP, 13'h0}) begin
            n_err++; $display("FAIL to_fire: got err %b cmd %b addr %h want 1 0111 0", grant_err, sdram_cmd, sdram_addr); end
        step();
        n_cmp++; if ({grant_err, wr_en, sdram_cmd} !== {2'b00, NOP}) begin
            n_err++; $display("FAIL to_after: got err %b wr_en %b cmd %b want 0 0 0111", grant_err, wr_en, sdram_cmd); end
    endtask

    task automatic test_reset_mid_grant();
        int rd_seen;
        wr_trig = 1'b1; rd_trig = 1'b1;
        step();
        wr_trig = 1'b0; rd_trig = 1'b0;
        step();
        wr_dq_oe = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({sdram_cke, dq_oe, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_ba} !== {4'b0, NOP, 13'h0, 2'h0}) begin
            n_err++; $display("FAIL mid_reset: got cke %b oe %b wr %b rd %b cmd %b addr %h ba %h", sdram_cke, dq_oe, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_ba); end
        wr_dq_oe = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if ({sdram_cke, sdram_cmd} !== {1'b1, NOP}) begin
            n_err++; $display("FAIL post_reset: got cke %b cmd %b want 1 0111", sdram_cke, sdram_cmd); end
        rd_seen = 0;
        repeat (6) begin
            step();
            if (rd_en || wr_en) rd_seen++;
        end
        n_cmp++; if (rd_seen !== 0) begin
            n_err++; $display("FAIL lost_pend: got %0d grants want 0", rd_seen); end
        rd_trig = 1'b1;
        step();
        rd_trig = 1'b0;
        step();
        n_cmp++; if (rd_en !== 1'b1) begin
            n_err++; $display("FAIL new_rd: got rd_en %b want 1", rd_en); end
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aref_priority();
        test_wr_over_rd();
        test_merge();
        test_timeout();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
Central sequencer for the SDRAM command bus inside sdram_top. It holds the bus for the init engine until power-up completes, then grants the bus to the auto-refresh, write and read engines. Grant priority is refresh > write > read. It latches the one-shot wr_trig/rd_trig pulses into pending requests. It muxes the granted engine's command/address/bank/DQ-enable onto the DRAM pins and guards each grant with a watchdog.

Parameters:
TIMEOUT, 1024, max cycles a grant may stay open without its end strobe
ADDR_W, 13, DRAM_ADDR width
BA_W, 2, DRAM_BA width

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst_n  in  1  async active-low reset
wr_trig  in  1  one-cycle write request pulse
rd_trig  in  1  one-cycle read request pulse
init_end  in  1  init engine done (level, stays high)
init_cmd  in  4  {CS_N,RAS_N,CAS_N,WE_N} from init engine
init_addr  in  ADDR_W  init address
aref_req  in  1  refresh request level, held until aref_en
aref_end  in  1  refresh done pulse
aref_cmd  in  4  refresh command
aref_addr  in  ADDR_W  refresh address
wr_end  in  1  write burst done pulse
wr_cmd  in  4  write command
wr_addr  in  ADDR_W  write address
wr_ba  in  BA_W  write bank
wr_dq_oe  in  1  write engine DQ drive enable
rd_end  in  1  read burst done pulse
rd_cmd  in  4  read command
rd_addr  in  ADDR_W  read address
rd_ba  in  BA_W  read bank
aref_en  out  1  one-cycle refresh grant
wr_en  out  1  one-cycle write grant
rd_en  out  1  one-cycle read grant
sdram_cmd  out  4  muxed command to pins
sdram_addr  out  ADDR_W  muxed address
sdram_ba  out  BA_W  muxed bank
sdram_cke  out  1  clock enable
dq_oe  out  1  DQ tristate enable
grant_err  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (async) values:
  - state=S_INIT; wr_pend=rd_pend=0; all *_en=0; grant_err=0; sdram_cke=0.
  - sdram_cmd=NOP (4'b0111); sdram_addr=0; sdram_ba=0; dq_oe=0; watchdog=0.
- sdram_cke: register set to 1 on the first clock after reset release; stays 1.
- Registered state machine, encoded one-hot: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ.
- S_INIT:
  - Output mux selects init_cmd/init_addr; ba=0.
  - When init_end is sampled high, go to S_ARBIT on the next cycle.
- S_ARBIT:
  - Outputs NOP, addr 0, ba 0, dq_oe 0.
  - Priority is aref_req > wr_pend > rd_pend. Winner is sampled at edge N; state enters the target at N+1.
  - The matching *_en is high during cycle N+1 only.
  - With no request, stay in S_ARBIT.
- S_AREF / S_WRITE / S_READ:
  - Output mux selects that engine's cmd/addr/ba.
  - dq_oe=wr_dq_oe in S_WRITE only, else 0.
  - The matching *_end sampled high returns to S_ARBIT next cycle. S_ARBIT lasts at least 1 cycle between grants.
- Output mux is combinational from the registered state; engines register their own outputs.
- Pending latches:
  - wr_trig sets wr_pend; wr_pend clears in the cycle wr_en is asserted.
  - A trig while pend=1 is merged (no count).
  - A trig coinciding with the clearing cycle sets pend again (set wins).
  - rd_trig/rd_pend follow the same rules.
- End strobes arriving outside their own state are ignored. init_end is ignored after S_INIT.
- Watchdog:
  - Counter clears on every grant and increments each cycle in S_AREF/S_WRITE/S_READ.
  - At TIMEOUT-1 without an end strobe: force S_ARBIT next cycle and pulse grant_err for 1 cycle.
  - The pending bit of the timed-out request stays cleared.
- aref_req high while a write/read is granted has no arbiter effect; the engines handle burst-boundary abort. It is served at the next S_ARBIT.
- Reset asserted mid-grant: immediate return to reset values; pending requests are lost.

Decomposition:
- Shared package sdram_pkg:
  - Command constants CMD_NOP=4'b0111, CMD_PRE, CMD_AREF, CMD_ACT, CMD_WR, CMD_RD, CMD_MRS.
  - State encodings.
  - ADDR_W/BA_W defaults.
- One natural sub-module, sdram_req_latch: set/clear pending bit, instantiated twice for write and read.

Test Plan:
- Reset held 100 ns, init_end rises at cycle 10,000 -> sdram_cke=1 at first edge after release; sdram_cmd follows init_cmd until init_end; S_ARBIT and cmd=4'b0111 the cycle after.
- aref_req and wr_trig in the same cycle in S_ARBIT -> aref_en pulse first. After aref_end, wr_en pulses 2 cycles later; wr_pend stays set meanwhile.
- wr_trig and rd_trig in the same cycle -> wr_en first. rd_en only after wr_end plus 1 S_ARBIT cycle; dq_oe follows wr_dq_oe only in S_WRITE.
- Three wr_trig pulses while in S_READ -> exactly one wr_en after rd_end. wr_trig coinciding with wr_en -> a second wr_en after wr_end.
- TIMEOUT=16, grant write, never assert wr_end -> grant_err pulses 16 cycles after wr_en; state back in S_ARBIT; cmd=NOP.
- rst_n dropped during S_WRITE with rd_pend=1 -> all outputs at reset values within the same cycle; no rd_en after reset until a new rd_trig.
